// File: rtl/cfr_pkg.sv
// rtl/cfr_pkg.sv - shared types and constants for the CFR power meter
package cfr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } cfr_pm_state_t;

  localparam int MAG2_LATENCY = 3;

endpackage

// File: rtl/cfr_mag2.sv
// rtl/cfr_mag2.sv - three-stage I^2+Q^2 pipeline with tag/last sideband
module cfr_mag2 #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [DATA_WIDTH-1:0]  data_i,
  input  logic signed [DATA_WIDTH-1:0]  data_q,
  input  logic                          tag_in,
  input  logic                          last_in,
  output logic [2*DATA_WIDTH-1:0]       mag2,
  output logic                          tag_out,
  output logic                          last_out
);

  localparam int MW = 2 * DATA_WIDTH;

  logic signed [DATA_WIDTH-1:0] i_r, q_r;
  logic signed [MW-1:0]         prod_i, prod_q;
  logic                         tag_r1, last_r1, tag_r2, last_r2;

  // Squares are non-negative and at most 2^(2*DATA_WIDTH-2), so the sum never wraps
  always_ff @(posedge clk) begin
    if (rst) begin
      i_r      <= '0;
      q_r      <= '0;
      prod_i   <= '0;
      prod_q   <= '0;
      mag2     <= '0;
      tag_r1   <= 1'b0;
      last_r1  <= 1'b0;
      tag_r2   <= 1'b0;
      last_r2  <= 1'b0;
      tag_out  <= 1'b0;
      last_out <= 1'b0;
    end else begin
      i_r      <= data_i;
      q_r      <= data_q;
      tag_r1   <= tag_in;
      last_r1  <= last_in;
      prod_i   <= MW'(i_r) * MW'(i_r);
      prod_q   <= MW'(q_r) * MW'(q_r);
      tag_r2   <= tag_r1;
      last_r2  <= last_r1;
      mag2     <= $unsigned(prod_i) + $unsigned(prod_q);
      tag_out  <= tag_r2;
      last_out <= last_r2;
    end
  end

endmodule

// File: rtl/cfr_power_meter.sv
// rtl/cfr_power_meter.sv - windowed power, peak and over-threshold statistics
module cfr_power_meter
  import cfr_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int WIN_WIDTH  = 16,
  parameter int ACC_WIDTH  = 2 * DATA_WIDTH + WIN_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [DATA_WIDTH-1:0]  data_i_in,
  input  logic signed [DATA_WIDTH-1:0]  data_q_in,
  input  logic                          ctrl_start,
  input  logic                          ctrl_continuous,
  input  logic [WIN_WIDTH-1:0]          ctrl_win_len,
  input  logic [2*DATA_WIDTH-1:0]       ctrl_threshold,
  output logic                          stat_busy,
  output logic                          stat_valid,
  output logic [ACC_WIDTH-1:0]          stat_power_acc,
  output logic [2*DATA_WIDTH-1:0]       stat_peak,
  output logic [WIN_WIDTH:0]            stat_over_cnt
);

  localparam int MW = 2 * DATA_WIDTH;
  localparam int CW = WIN_WIDTH + 1;
  // FLUSH lasts until the final tag has crossed the pipeline, accumulator and output stage
  localparam logic [WIN_WIDTH-1:0] FLUSH_LAST = WIN_WIDTH'(MAG2_LATENCY + 1);

  cfr_pm_state_t         state, state_nxt;
  logic [WIN_WIDTH-1:0]  cnt, win_len_r;
  logic [MW-1:0]         thr_r;
  logic                  tag_in, last_in, load_win;

  always_comb begin
    tag_in    = (state == RUN);
    last_in   = tag_in && (cnt == win_len_r);
    load_win  = ((state == IDLE) && ctrl_start) || (last_in && ctrl_continuous);
    state_nxt = state;
    case (state)
      IDLE:    if (ctrl_start) state_nxt = RUN;
      RUN:     if (last_in && !ctrl_continuous) state_nxt = FLUSH;
      FLUSH:   if (cnt == FLUSH_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      win_len_r <= '0;
      thr_r     <= '0;
    end else begin
      state <= state_nxt;
      if (load_win) begin
        win_len_r <= ctrl_win_len;
        thr_r     <= ctrl_threshold;
      end
      // The window counter doubles as the flush timer once the last sample is in
      if (state == IDLE || last_in) cnt <= '0;
      else                          cnt <= cnt + 1'b1;
    end
  end

  assign stat_busy = (state != IDLE);

  logic [MW-1:0] mag2;
  logic          tag_out, last_out;

  cfr_mag2 #(.DATA_WIDTH(DATA_WIDTH)) u_mag2 (
    .clk      (clk),
    .rst      (rst),
    .data_i   (data_i_in),
    .data_q   (data_q_in),
    .tag_in   (tag_in),
    .last_in  (last_in),
    .mag2     (mag2),
    .tag_out  (tag_out),
    .last_out (last_out)
  );

  // Threshold travels alongside its samples so back-to-back windows keep their own value
  logic [MW-1:0] thr_pipe [MAG2_LATENCY];

  always_ff @(posedge clk) begin
    thr_pipe[0] <= thr_r;
    for (int i = 1; i < MAG2_LATENCY; i++) thr_pipe[i] <= thr_pipe[i-1];
  end

  logic [ACC_WIDTH-1:0] acc;
  logic [MW-1:0]        peak;
  logic [CW-1:0]        over_cnt;
  logic                 acc_open, acc_last, over;

  assign over = (mag2 > thr_pipe[MAG2_LATENCY-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      peak     <= '0;
      over_cnt <= '0;
      acc_open <= 1'b0;
      acc_last <= 1'b0;
    end else begin
      acc_last <= tag_out && last_out;
      if (tag_out) begin
        acc_open <= !last_out;
        if (!acc_open) begin
          acc      <= ACC_WIDTH'(mag2);
          peak     <= mag2;
          over_cnt <= CW'(over);
        end else begin
          acc      <= acc + ACC_WIDTH'(mag2);
          peak     <= (mag2 > peak) ? mag2 : peak;
          over_cnt <= over_cnt + CW'(over);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_valid     <= 1'b0;
      stat_power_acc <= '0;
      stat_peak      <= '0;
      stat_over_cnt  <= '0;
    end else begin
      stat_valid <= acc_last;
      if (acc_last) begin
        stat_power_acc <= acc;
        stat_peak      <= peak;
        stat_over_cnt  <= over_cnt;
      end
    end
  end

endmodule
